// File: rtl/pio_key_sw_in_if.sv
// pio_key_sw_in_if: Avalon-MM slave bus of the KEY/SW input PIO.
// The HPS lightweight bridge drives the master side and the PIO is the slave.
interface pio_key_sw_in_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pio_key_sw_in.sv
// pio_key_sw_in: input-direction PIO for the board KEY/SW levels.
// Each bit is synchronised, debounced and edge-captured. Captured edges that
// are unmasked raise a level interrupt towards the HPS.
// Register map: 0 DATA (debounced), 1 IRQ_MASK, 2 EDGE_CAPTURE (W1C), 3 RAW.
// Build option: define PIO_IN_DEBOUNCE_EN to include the per-bit debounce
// counters. Without it, the debounced value simply follows the synchroniser.
module pio_key_sw_in #(
    parameter int              WIDTH           = 8,
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter int              CNT_W           = 20,
    parameter int              EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VAL      = WIDTH'('h0F)
) (
    input  logic               clk,
    input  logic               reset_n,
    pio_key_sw_in_if.slave     avs,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic             w_mask_wr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    // Two-flop synchroniser for the asynchronous board inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [WIDTH];

    // Per-bit debounce: a new level is accepted only after it persists long enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    // Without debounce the accepted level follows the synchroniser output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= RESET_VAL;
        end else begin
            r_stable <= r_sync2;
        end
    end
`endif

    assign w_rise    = ~r_prev & r_stable;
    assign w_fall    = r_prev & ~r_stable;
    assign w_edge    = (EDGE_TYPE == 0) ? w_rise :
                       (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);
    assign w_w1c     = (avs.write && (avs.address == 2'd2)) ? avs.writedata[WIDTH-1:0] : '0;
    assign w_mask_wr = avs.write && (avs.address == 2'd1);

    assign w_unused_wdata = ^avs.writedata[31:WIDTH];

    // Edge capture is sticky; a new edge overrides a simultaneous W1C clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= RESET_VAL;
            r_edge <= '0;
        end else begin
            r_prev <= r_stable;
            r_edge <= (r_edge & ~w_w1c) | w_edge;
        end
    end

    // Interrupt mask register, written from the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_mask_wr) begin
            r_mask <= avs.writedata[WIDTH-1:0];
        end
    end

    // Read mux; unused upper bits return zero.
    always_comb begin
        w_rdata = '0;
        case (avs.address)
            2'd0:    w_rdata[WIDTH-1:0] = r_stable;
            2'd1:    w_rdata[WIDTH-1:0] = r_mask;
            2'd2:    w_rdata[WIDTH-1:0] = r_edge;
            default: w_rdata[WIDTH-1:0] = r_sync2;
        endcase
    end

    // Read data is registered on the read strobe and held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (avs.read) begin
            r_readdata <= w_rdata;
        end
    end

    // Level interrupt: any captured edge that is also unmasked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign avs.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pio_key_sw_in.sv
// tb_pio_key_sw_in: directed bench for the KEY/SW input PIO.
// Expected latencies follow the build: with PIO_IN_DEBOUNCE_EN the input to
// DATA latency is 2 + DEBOUNCE_CYCLES, otherwise 3 cycles.
module tb_pio_key_sw_in;

    localparam int WIDTH = 8;
    localparam int DEB   = 16;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;
    logic             irq;
    logic [31:0]      rd;

    int testsRun    = 0;
    int testsFailed = 0;

    pio_key_sw_in_if bus ();

    pio_key_sw_in #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (5),
        .EDGE_TYPE      (1),
        .RESET_VAL      (8'h0F)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .avs    (bus.slave),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] value);
        in_port = value;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        bus.read    = 1'b1;
        @(posedge clk);
        #1;
        bus.read = 1'b0;
        data     = bus.readdata;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        bus.address   = addr;
        bus.writedata = data;
        bus.write     = 1'b1;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.address   = 2'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'h0;
        applyStimulus(8'h0F);
        waitCycles(3);
        checkOutput("resetReaddata", bus.readdata, 32'h0);
        checkOutput("resetIrq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        waitCycles(2);

        // Register map after reset
        busRead(2'd0, rd); checkOutput("resetData", rd, 32'h0F);
        busRead(2'd1, rd); checkOutput("resetMask", rd, 32'h00);
        busRead(2'd2, rd); checkOutput("resetEdge", rd, 32'h00);
        busRead(2'd3, rd); checkOutput("resetRaw", rd, 32'h0F);

        // KEY0 press: exact latency to DATA, then capture and W1C
        applyStimulus(8'h0E);
        waitCycles(LAT - 1);
        busRead(2'd0, rd); checkOutput("key0DataBefore", rd, 32'h0F);
        busRead(2'd0, rd); checkOutput("key0DataAfter", rd, 32'h0E);
        busRead(2'd2, rd); checkOutput("key0Edge", rd, 32'h01);
        checkOutput("key0IrqMasked", {31'h0, irq}, 32'h0);
        waitCycles(30 - LAT - 2);
        busWrite(2'd0, 32'h55);
        busWrite(2'd2, 32'h01);
        busRead(2'd2, rd); checkOutput("key0EdgeCleared", rd, 32'h00);
        busRead(2'd0, rd); checkOutput("dataWriteIgnored", rd, 32'h0E);

        // KEY0 release is a rising edge and is not captured
        applyStimulus(8'h0F);
        waitCycles(LAT + 2);
        busRead(2'd0, rd); checkOutput("key0Release", rd, 32'h0F);
        busRead(2'd2, rd); checkOutput("key0RiseIgnored", rd, 32'h00);

`ifdef PIO_IN_DEBOUNCE_EN
        // 10-cycle glitch on KEY1 is visible on RAW only
        applyStimulus(8'h0D);
        waitCycles(4);
        busRead(2'd3, rd); checkOutput("glitchRaw", rd, 32'h0D);
        busRead(2'd0, rd); checkOutput("glitchDataDuring", rd, 32'h0F);
        waitCycles(4);
        applyStimulus(8'h0F);
        waitCycles(LAT + 4);
        busRead(2'd0, rd); checkOutput("glitchDataAfter", rd, 32'h0F);
        busRead(2'd2, rd); checkOutput("glitchNoEdge", rd, 32'h00);
`endif

        // Masked KEY1 press raises irq one cycle after capture
        busWrite(2'd1, 32'h02);
        busRead(2'd1, rd); checkOutput("maskReadback", rd, 32'h02);
        applyStimulus(8'h0D);
        waitCycles(LAT + 1);
        checkOutput("irqNotYet", {31'h0, irq}, 32'h0);
        waitCycles(1);
        checkOutput("irqRaised", {31'h0, irq}, 32'h1);
        busRead(2'd2, rd); checkOutput("key1Edge", rd, 32'h02);

        // W1C in the same cycle as a new capture: the set wins
        applyStimulus(8'h0F);
        waitCycles(LAT + 2);
        checkOutput("irqSticky", {31'h0, irq}, 32'h1);
        applyStimulus(8'h0D);
        waitCycles(LAT);
        busWrite(2'd2, 32'h02);
        waitCycles(1);
        checkOutput("setWinsIrq", {31'h0, irq}, 32'h1);
        busRead(2'd2, rd); checkOutput("setWinsEdge", rd, 32'h02);

        // SW4 switched on: rising edge updates DATA but not EDGE_CAPTURE
        applyStimulus(8'h0F);
        waitCycles(LAT + 2);
        applyStimulus(8'h1F);
        waitCycles(LAT + 2);
        busRead(2'd0, rd); checkOutput("sw4Data", rd, 32'h1F);
        busRead(2'd2, rd); checkOutput("sw4EdgeUnchanged", rd, 32'h02);

        // Mask clear drops irq one cycle later, restore raises it again
        busWrite(2'd1, 32'h00);
        checkOutput("irqHoldMaskClr", {31'h0, irq}, 32'h1);
        waitCycles(1);
        checkOutput("irqMaskClr", {31'h0, irq}, 32'h0);
        busWrite(2'd1, 32'h02);
        waitCycles(1);
        checkOutput("irqMaskRestore", {31'h0, irq}, 32'h1);

        // Reset at debounce count 8 clears everything asynchronously
        applyStimulus(8'h1E);
        waitCycles(10);
        checkOutput("irqBeforeReset", {31'h0, irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("irqAsyncReset", {31'h0, irq}, 32'h0);
        checkOutput("readdataAsyncReset", bus.readdata, 32'h0);
        waitCycles(1);
        reset_n = 1'b1;
        busRead(2'd0, rd); checkOutput("pendingDiscarded", rd, 32'h0F);
        busRead(2'd1, rd); checkOutput("maskAfterReset", rd, 32'h00);
        busRead(2'd2, rd); checkOutput("edgeAfterReset", rd, 32'h00);

        // Held input is re-debounced after reset
        waitCycles(LAT + 4);
        busRead(2'd0, rd); checkOutput("dataAfterRedebounce", rd, 32'h1E);
        busRead(2'd2, rd); checkOutput("edgeAfterRedebounce", rd, 32'h01);
        checkOutput("irqMaskZero", {31'h0, irq}, 32'h0);
        busWrite(2'd1, 32'h01);
        waitCycles(1);
        checkOutput("irqMask0", {31'h0, irq}, 32'h1);
        busWrite(2'd2, 32'h01);
        checkOutput("irqHoldW1c", {31'h0, irq}, 32'h1);
        waitCycles(1);
        checkOutput("irqW1cClear", {31'h0, irq}, 32'h0);

        // Multi-bit change to 0x0A with exact latency
        applyStimulus(8'h0A);
        waitCycles(LAT - 1);
        busRead(2'd0, rd); checkOutput("multiDataBefore", rd, 32'h1E);
        busRead(2'd0, rd); checkOutput("multiDataAfter", rd, 32'h0A);
        busRead(2'd2, rd); checkOutput("multiEdge", rd, 32'h14);
        busRead(2'd3, rd); checkOutput("multiRaw", rd, 32'h0A);
        checkOutput("multiIrq", {31'h0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
